ahb_apb_bridge: RTL

AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

---
 rtl/ahb_apb_bridge.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB master bridge.
//
// Each accepted AHB transfer is decoded to one of NUM_SLAVES APB slaves.
// The decode uses the 4-bit field haddr[SLV_REGION_BITS +: 4].
// An APB SETUP/ACCESS sequence then runs for that slave.
// An unmapped index, a pslverr, or an ACCESS phase that stays longer than
// TIMEOUT cycles all end in a two-cycle AHB ERROR response.
// Every AHB and APB output is registered.
//
// Ports
//   hclk, hreset_n        clock, synchronous active-low reset
//   hsel .. hwdata        AHB-Lite slave inputs
//   hreadyout, hresp,     AHB-Lite slave outputs
//   hrdata
//   psel .. pwdata        APB master outputs (psel one-hot per slave)
//   prdata, pready,       APB slave returns, packed per slave
//   pslverr               (prdata slice i = [i*DATA_WIDTH +: DATA_WIDTH])
//
// state  | meaning
// IDLE   | no transfer in flight, zero-wait OKAY
// CAPT   | data phase start, capture hwdata on writes
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, wait for pready or timeout
// DONE   | OKAY response, may accept next transfer
// ERR1   | first ERROR cycle (hreadyout=0)
// ERR2   | second ERROR cycle (hreadyout=1), may accept next transfer

module ahb_apb_bridge #(
  parameter int NUM_SLAVES      = 12,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SLV_REGION_BITS = 12,
  parameter int TIMEOUT         = 16
) (
  input  logic                             hclk,
  input  logic                             hreset_n,
  input  logic                             hsel,
  input  logic [ADDR_WIDTH-1:0]            haddr,
  input  logic [1:0]                       htrans,
  input  logic                             hwrite,
  input  logic                             hready,
  input  logic [DATA_WIDTH-1:0]            hwdata,
  output logic                             hreadyout,
  output logic                             hresp,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CAPT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR1   = 3'd5;
  localparam logic [2:0] S_ERR2   = 3'd6;

  // Down-counter loaded with TIMEOUT-1 on entry to ACCESS.
  // Reaching zero without pready means TIMEOUT ACCESS cycles have elapsed.
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [3:0]            idx_q;
  logic [CNT_W-1:0]      cnt;

  logic                  accept;
  logic                  can_accept;
  logic [3:0]            haddr_idx;
  logic                  map_ok;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  timeout_hit;
  logic [NUM_SLAVES-1:0] sel_vec;

  assign haddr_idx   = haddr[SLV_REGION_BITS +: 4];
  assign map_ok      = ({1'b0, haddr_idx} < 5'(NUM_SLAVES));
  assign can_accept  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
  assign accept      = can_accept && hsel && hready && htrans[1];
  assign timeout_hit = (TIMEOUT != 0) && (cnt == '0);
  assign sel_vec     = NUM_SLAVES'(1) << idx_q;

  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    rd_sel      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
        rd_sel      = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) state_nxt = map_ok ? S_CAPT : S_ERR1;
        else        state_nxt = S_IDLE;
      end
      S_CAPT:  state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_ACCESS;
      S_ACCESS: begin
        // pready takes priority over a timeout landing in the same cycle
        if (pready_sel)       state_nxt = pslverr_sel ? S_ERR1 : S_DONE;
        else if (timeout_hit) state_nxt = S_ERR1;
        else                  state_nxt = S_ACCESS;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      cnt       <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        idx_q   <= haddr_idx;
      end

      // Outputs are registered from the next state so that they line up with it.
      hreadyout <= (state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR2);
      hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
      psel      <= ((state_nxt == S_SETUP) || (state_nxt == S_ACCESS)) ? sel_vec : '0;
      penable   <= (state_nxt == S_ACCESS);

      if (state_nxt == S_SETUP) begin
        paddr  <= addr_q;
        pwrite <= write_q;
      end

      if ((state == S_CAPT) && write_q) pwdata <= hwdata;

      if (state == S_SETUP)
        cnt <= CNT_W'(TO_LOAD);
      else if ((state == S_ACCESS) && !pready_sel && (cnt != '0))
        cnt <= cnt - 1'b1;

      if ((state == S_ACCESS) && pready_sel && !pslverr_sel && !write_q)
        hrdata <= rd_sel;
    end
  end

endmodule
